// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam int ARB_MAX_D_BURST = 4;

  // Fetches are always full-word loads.
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, data port and backend command/response signals.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_abort;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, d_funct3,
           mem_ack, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
  );

  // Requester and backend side.
  modport master (
    output if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, d_funct3,
           mem_ack, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory backend between instruction fetch and data access; data
// wins by default, but a pending fetch wins after MAX_D_BURST data grants.
module mem_bus_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = ARB_MAX_D_BURST
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int             CNT_W     = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_D_BURST);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic if_elig, fetch_wins, grant_if, grant_d;

  always_comb begin
    if_elig    = bus.if_req && !bus.if_abort;
    fetch_wins = if_elig && (!bus.d_req || burst_cnt_q == BURST_MAX);
    // A requester whose done is pulsing still shows its serviced req; if that
    // stale req would win, nobody is granted this cycle.
    grant_if   = fetch_wins && !if_done_q;
    grant_d    = bus.d_req && !fetch_wins && !d_done_q;
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_funct3_d = FETCH_FUNCT3;
          burst_cnt_d  = '0;
          drop_d       = 1'b0;
        end else if (grant_d) begin
          state_d      = BUSY_D;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.d_we;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
          mem_funct3_d = bus.d_funct3;
          burst_cnt_d  = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
        end
      end
      BUSY_IF: begin
        drop_d = drop_q || bus.if_abort;
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A flushed fetch still finishes on the backend but is never reported.
          if (!drop_q && !bus.if_abort) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_funct3 = mem_funct3_q;
  assign bus.if_done    = if_done_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_done     = d_done_q;
  assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against
// a requester/backend scoreboard model.
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_abort  = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_funct3  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_done, bus.d_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: mem_req/we/if_done/d_done=%b want 0000",
               {bus.mem_req, bus.mem_we, bus.if_done, bus.d_done});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_funct3 !== 3'b000) begin
      errors++;
      $display("FAIL reset_cmd: addr=%h wdata=%h f3=%b want all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_funct3);
    end
    checks++;
    if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h want 0", bus.if_rdata, bus.d_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100 ||
        bus.mem_funct3 !== 3'b010 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_cmd: req=%b we=%b addr=%h f3=%b wdata=%h want 1 0 100 010 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_funct3, bus.mem_wdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00500093;
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h00500093 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: if_done=%b if_rdata=%h mem_req=%b want 1 00500093 0",
               bus.if_done, bus.if_rdata, bus.mem_req);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    bus.if_req    = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b0 || bus.if_rdata !== 32'h00500093 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold: if_done=%b if_rdata=%h mem_req=%b want 0 00500093 0",
               bus.if_done, bus.if_rdata, bus.mem_req);
    end
  endtask

  task automatic test_priority();
    bus.if_addr  = 32'h200;
    bus.if_req   = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h2000;
    bus.d_wdata  = 32'hDEADBEEF;
    bus.d_funct3 = 3'b010;
    bus.d_req    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h2000 ||
        bus.mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_data_first: req=%b we=%b addr=%h wdata=%h want 1 1 2000 deadbeef",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.d_done !== 1'b1 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL prio_d_done: d_done=%b if_done=%b want 1 0", bus.d_done, bus.if_done);
    end
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL prio_fetch_next: req=%b we=%b addr=%h want 1 0 200",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h0000_0013 || bus.d_done !== 1'b0) begin
      errors++;
      $display("FAIL prio_if_done: if_done=%b if_rdata=%h d_done=%b want 1 00000013 0",
               bus.if_done, bus.if_rdata, bus.d_done);
    end
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst_limit();
    string seq = "";
    int    n = 0;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h3000;
    bus.d_funct3 = 3'b010;
    bus.d_req    = 1'b1;
    bus.if_addr  = 32'h500;
    bus.if_req   = 1'b1;
    for (int cyc = 0; cyc < 80 && n < 6; cyc++) begin
      @(negedge clk);
      if (bus.d_done === 1'b1) begin seq = {seq, "D"}; n++; end
      if (bus.if_done === 1'b1) begin seq = {seq, "F"}; n++; bus.if_req = 1'b0; end
      if (n >= 6) bus.d_req = 1'b0;
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = $urandom;
    end
    checks++;
    if (seq != "DDDDFD") begin
      errors++;
      $display("FAIL burst_order: done sequence %s want DDDDFD", seq);
    end
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL burst_quiet: mem_req=%b want 0", bus.mem_req);
    end
  endtask

  task automatic test_abort_busy();
    logic [31:0] last_if = bus.if_rdata;
    bus.if_addr = 32'h300;
    bus.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL abort_grant: mem_req=%b addr=%h want 1 300", bus.mem_req, bus.mem_addr);
    end
    bus.if_abort = 1'b1;
    bus.if_req   = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      bus.if_abort = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.if_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold: cycle %0d mem_req=%b if_done=%b want 1 0", k, bus.mem_req, bus.if_done);
      end
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.if_done !== 1'b0 || bus.if_rdata !== last_if) begin
      errors++;
      $display("FAIL abort_drop: mem_req=%b if_done=%b if_rdata=%h want 0 0 %h",
               bus.mem_req, bus.if_done, bus.if_rdata, last_if);
    end
    bus.mem_ack  = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h44;
    bus.d_funct3 = 3'b000;
    bus.d_req    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: mem_req=%b addr=%h if_done=%b want 1 44 0",
               bus.mem_req, bus.mem_addr, bus.if_done);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    checks++;
    if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL abort_data_after: d_done=%b d_rdata=%h want 1 cafe0001", bus.d_done, bus.d_rdata);
    end
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h40;
    bus.d_wdata  = 32'h11112222;
    bus.d_funct3 = 3'b001;
    bus.d_req    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: mem_req=%b mem_we=%b want 1 1", bus.mem_req, bus.mem_we);
    end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.d_req = 1'b0;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_done, bus.d_done} !== 4'b0000 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_funct3 !== 3'b000 ||
        bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_zero: req/we/ifd/dd=%b addr=%h wdata=%h f3=%b ifr=%h dr=%h want all 0",
               {bus.mem_req, bus.mem_we, bus.if_done, bus.d_done}, bus.mem_addr,
               bus.mem_wdata, bus.mem_funct3, bus.if_rdata, bus.d_rdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.d_done !== 1'b0 || bus.mem_req !== 1'b0 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_stray_ack: d_done=%b mem_req=%b d_rdata=%h want 0 0 0",
               bus.d_done, bus.mem_req, bus.d_rdata);
    end
    bus.if_addr = 32'h600;
    bus.if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h600 || bus.d_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: mem_req=%b addr=%h d_done=%b want 1 600 0",
               bus.mem_req, bus.mem_addr, bus.d_done);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h13;
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h13) begin
      errors++;
      $display("FAIL rstmid_fetch: if_done=%b if_rdata=%h want 1 13", bus.if_done, bus.if_rdata);
    end
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_with_new_req();
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h80;
    bus.d_funct3 = 3'b100;
    bus.d_req    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h80 || bus.mem_funct3 !== 3'b100) begin
      errors++;
      $display("FAIL acknew_load: req=%b we=%b addr=%h f3=%b want 1 0 80 100",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_funct3);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    bus.if_addr   = 32'h400;
    bus.if_req    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h12345678 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL acknew_done: d_done=%b d_rdata=%h mem_req=%b want 1 12345678 0",
               bus.d_done, bus.d_rdata, bus.mem_req);
    end
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL acknew_fetch: mem_req=%b addr=%h we=%b want 1 400 0",
               bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h9;
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h9) begin
      errors++;
      $display("FAIL acknew_if_done: if_done=%b if_rdata=%h want 1 9", bus.if_done, bus.if_rdata);
    end
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    @(negedge clk);
  endtask

  // Requesters issue random transactions and drop req when they see done; the
  // backend acks after a random delay. The model predicts who is served next.
  task automatic test_random();
    bit          f_act = 0, d_act = 0, outst = 0, out_f = 0, grant_exp = 0, busy;
    bit          f_done_now, d_done_now;
    int          pend = 0, wait_cnt = 0, dcount = 0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [2:0]  exp_f3 = '0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      checks++;
      if (bus.if_done !== 1'(pend == 1) || bus.d_done !== 1'(pend == 2)) begin
        errors++;
        $display("FAIL rnd_done: cyc %0d if_done=%b d_done=%b want %b %b",
                 cyc, bus.if_done, bus.d_done, pend == 1, pend == 2);
      end
      f_done_now = (pend == 1);
      d_done_now = (pend == 2);
      if (f_done_now) begin
        checks++;
        if (bus.if_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL rnd_if_rdata: cyc %0d got %h want %h", cyc, bus.if_rdata, exp_rdata);
        end
        f_act = 0; bus.if_req = 1'b0;
      end
      if (d_done_now) begin
        checks++;
        if (bus.d_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL rnd_d_rdata: cyc %0d got %h want %h", cyc, bus.d_rdata, exp_rdata);
        end
        d_act = 0; bus.d_req = 1'b0;
      end
      pend = 0;
      bus.mem_ack = 1'b0;
      if (grant_exp) begin
        outst = 1; wait_cnt = $urandom_range(0, 3); grant_exp = 0;
      end
      checks++;
      if (outst) begin
        if (bus.mem_req !== 1'b1 || bus.mem_we !== exp_we || bus.mem_addr !== exp_addr ||
            bus.mem_wdata !== exp_wdata || bus.mem_funct3 !== exp_f3) begin
          errors++;
          $display("FAIL rnd_cmd: cyc %0d req=%b we=%b addr=%h wd=%h f3=%b want 1 %b %h %h %b",
                   cyc, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_funct3,
                   exp_we, exp_addr, exp_wdata, exp_f3);
        end
      end else if (bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle: cyc %0d mem_req=%b want 0", cyc, bus.mem_req);
      end
      busy = outst;
      if (outst) begin
        if (wait_cnt == 0) begin
          exp_rdata     = $urandom;
          bus.mem_rdata = exp_rdata;
          bus.mem_ack   = 1'b1;
          pend          = out_f ? 1 : 2;
          outst         = 0;
        end else begin
          wait_cnt--;
        end
      end
      if (cyc < 300) begin
        if (!f_act && !f_done_now && $urandom_range(0, 2) == 0) begin
          f_act = 1; bus.if_addr = $urandom; bus.if_req = 1'b1;
        end
        if (!d_act && !d_done_now && $urandom_range(0, 2) == 0) begin
          d_act        = 1;
          bus.d_we     = 1'($urandom_range(0, 1));
          bus.d_addr   = $urandom;
          bus.d_wdata  = $urandom;
          bus.d_funct3 = 3'($urandom_range(0, 7));
          bus.d_req    = 1'b1;
        end
      end
      if (!busy && (f_act || d_act)) begin
        grant_exp = 1;
        out_f     = f_act && (!d_act || dcount == MAXB);
        if (out_f) begin
          exp_we = 1'b0; exp_addr = bus.if_addr; exp_wdata = '0; exp_f3 = 3'b010;
          dcount = 0;
        end else begin
          exp_we = bus.d_we; exp_addr = bus.d_addr; exp_wdata = bus.d_wdata; exp_f3 = bus.d_funct3;
          dcount = (dcount < MAXB) ? dcount + 1 : MAXB;
        end
      end
    end
    checks++;
    if (outst || pend != 0 || grant_exp || f_act || d_act) begin
      errors++;
      $display("FAIL rnd_drain: outstanding=%b pend=%0d grant=%b f=%b d=%b want all 0",
               outst, pend, grant_exp, f_act, d_act);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_priority();
    test_burst_limit();
    test_abort_busy();
    test_reset_mid();
    test_ack_with_new_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_D_BURST, default 4, the number of consecutive data grants after which a pending fetch wins.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_req  in  1  fetch request, level, held until if_done or if_abort.
REQ-007 if_addr  in  ADDR_W  fetch address, stable while if_req.
REQ-008 if_abort  in  1  kill the current fetch (branch/jump flush).
REQ-009 if_done  out  1  one-cycle pulse, fetch data valid.
REQ-010 if_rdata  out  DATA_W  fetched instruction, valid with if_done.
REQ-011 d_req  in  1  data request, level, held until d_done.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_funct3  in  3  access size/sign, passed through.
REQ-016 d_done  out  1  one-cycle pulse, access complete.
REQ-017 d_rdata  out  DATA_W  load data, valid with d_done.
REQ-018 mem_req  out  1  backend request, registered, held until mem_ack.
REQ-019 mem_we, mem_addr, mem_wdata, mem_funct3  out  1/ADDR_W/DATA_W/3  registered backend command.
REQ-020 mem_ack  in  1  backend completion pulse, one or more cycles after mem_req rises.
REQ-021 mem_rdata  in  DATA_W  backend read data, valid with mem_ack.

Function
REQ-022 SHALL implement the FSM states IDLE, BUSY_IF and BUSY_D.
REQ-023 In IDLE with any request, SHALL choose a winner, latch its command into the mem_* registers, and enter the BUSY state of the winner; mem_req SHALL rise the next cycle.
REQ-024 Priority SHALL be: d_req wins over if_req, unless burst_cnt == MAX_D_BURST and if_req is set, in which case the fetch wins.
REQ-025 burst_cnt SHALL increment (saturating at MAX_D_BURST) on each data grant and SHALL clear on each fetch grant.
REQ-026 A fetch command SHALL drive mem_we = 0, mem_funct3 = 3'b010 and mem_wdata = 0.
REQ-027 In a BUSY state, mem_* SHALL hold constant until mem_ack.
REQ-028 On mem_ack in a BUSY state: the FSM SHALL go to IDLE, deassert mem_req, register mem_rdata into the winner's rdata, and pulse the winner's done for one cycle.
REQ-029 Minimum latency SHALL be: request seen at cycle N, mem_req at N+1, mem_ack at N+1, done at N+2; the next grant decision is at N+2 and its mem_req is at N+3.
REQ-030 A requester SHALL NOT be re-granted in the cycle its done pulses; its req is treated as already serviced in that cycle.
REQ-031 if_abort in IDLE SHALL suppress the fetch grant for that cycle.
REQ-032 if_abort in BUSY_IF SHALL set a drop flag; the transaction SHALL complete on the backend, but if_done SHALL be suppressed.
REQ-033 if_abort in the same cycle as mem_ack in BUSY_IF SHALL suppress if_done.
REQ-034 if_abort SHALL never affect a data transaction.
REQ-035 mem_ack in IDLE SHALL be ignored.
REQ-036 mem_ack in a BUSY state before mem_req has been registered high is not a legal backend behaviour.
REQ-037 if_rdata and d_rdata SHALL hold their last value between done pulses.

Reset
REQ-038 While rst is high at a clock edge, the block SHALL set: state = IDLE; burst_cnt = 0; drop flag = 0; mem_req, if_done, d_done, mem_we = 0; all data/address outputs = 0.
REQ-039 Reset mid-transaction SHALL abandon it; no done pulse, and a later mem_ack for it is ignored per REQ-035.

Structure
REQ-040 riscv_pkg SHALL hold arb_state_t (IDLE, BUSY_IF, BUSY_D) and the default constant ARB_MAX_D_BURST = 4.
REQ-041 SHALL be a single module with no sub-module; the priority pick is inline combinational logic feeding the registered command.

Verification
REQ-042 Bench SHALL cover: if_req addr 0x100, backend acks 1 cycle after mem_req, mem_rdata 0x00500093 -> mem_req 1 cycle after request, mem_we 0, if_done 2 cycles after request with if_rdata 0x00500093.
REQ-043 Bench SHALL cover: if_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF) rise in the same cycle -> data served first with mem_we 1, d_done pulses, then fetch served, if_done pulses.
REQ-044 Bench SHALL cover: d_req held continuously with if_req pending, MAX_D_BURST = 4 -> exactly 4 d_done pulses, then 1 if_done pulse, then data resumes.
REQ-045 Bench SHALL cover: if_abort pulsed in BUSY_IF with backend ack delayed 3 cycles -> mem_req held 3 cycles, no if_done, FSM returns to IDLE.
REQ-046 Bench SHALL cover: rst asserted 1 cycle in BUSY_D, then a stray mem_ack -> all outputs 0, d_done never pulses, state stays IDLE.
REQ-047 Bench SHALL cover: load with mem_ack in the same cycle as a new if_req -> d_done pulses, if_req is not granted that cycle, fetch mem_req appears 1 cycle later.
